// File: rtl/line_burst_engine_pkg.sv
// Shared constants and FSM state type for the memory-side line burst engine.
package line_burst_engine_pkg;

    localparam int unsigned LINE_ADDR_W   = 32;
    localparam int unsigned LINE_DATA_W   = 32;
    localparam int unsigned LINE_WORDS    = 16;
    localparam int unsigned LINE_OFFSET_W = 6;
    localparam int unsigned LINE_IDX_W    = $clog2(LINE_WORDS);
    localparam int unsigned LINE_TAG_W    = LINE_ADDR_W - LINE_OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_RDATA,
        ST_DONE
    } lbe_state_e;

endpackage

// File: rtl/line_burst_engine_if.sv
// Request, cache-array and main-memory signals of the line burst engine.
// master = engine side, slave = controller / memory / testbench side.
interface line_burst_engine_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;

    logic [IDX_W-1:0]  wb_word_idx;
    logic [DATA_W-1:0] wb_data;
    logic              fill_valid;
    logic [IDX_W-1:0]  fill_idx;
    logic [DATA_W-1:0] fill_data;
    logic              done;
    logic              err;

    logic              mem_cmd_valid;
    logic              mem_cmd_ready;
    logic              mem_cmd_write;
    logic [ADDR_W-1:0] mem_cmd_addr;
    logic              mem_wdata_valid;
    logic              mem_wdata_ready;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wlast;
    logic              mem_rdata_valid;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rlast;

    modport master (
        input  req_valid, req_write, req_addr, wb_data,
               mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata, mem_rlast,
        output req_ready, wb_word_idx, fill_valid, fill_idx, fill_data, done, err,
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
               mem_wdata_valid, mem_wdata, mem_wlast
    );

    modport slave (
        output req_valid, req_write, req_addr, wb_data,
               mem_cmd_ready, mem_wdata_ready, mem_rdata_valid, mem_rdata, mem_rlast,
        input  req_ready, wb_word_idx, fill_valid, fill_idx, fill_data, done, err,
               mem_cmd_valid, mem_cmd_write, mem_cmd_addr,
               mem_wdata_valid, mem_wdata, mem_wlast
    );

endinterface

// File: rtl/line_burst_engine_beat_counter.sv
// Wrapping beat counter shared by the write and read data phases.
module beat_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clear_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o,
    output logic             last_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Line length is a power of two, so the final beat is the all-ones count.
    assign last_o  = &count_q;

endmodule

// File: rtl/line_burst_engine.sv
// Turns one line refill or writeback request into a fixed-length memory burst,
// streaming refill words to the cache array and fetching writeback words from it.
module line_burst_engine
    import line_burst_engine_pkg::*;
#(
    parameter int unsigned ADDR_W         = LINE_ADDR_W,
    parameter int unsigned DATA_W         = LINE_DATA_W,
    parameter int unsigned WORDS_PER_LINE = LINE_WORDS,
    parameter int unsigned OFFSET_W       = LINE_OFFSET_W
) (
    input logic                  clk,
    input logic                  rst_b,
    line_burst_engine_if.master  bus
);

    localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'((64'd1 << OFFSET_W) - 64'd1);

    lbe_state_e        state_q;
    logic              req_ready_q;
    logic              cmd_valid_q;
    logic              cmd_write_q;
    logic [ADDR_W-1:0] cmd_addr_q;
    logic              wdata_valid_q;
    logic              fill_valid_q;
    logic [IDX_W-1:0]  fill_idx_q;
    logic [DATA_W-1:0] fill_data_q;
    logic              done_q;
    logic              err_q;

    logic [IDX_W-1:0]  beat;
    logic              beat_last;
    logic              cmd_hs;
    logic              wbeat_hs;
    logic              rbeat_hs;

    assign cmd_hs   = (state_q == ST_CMD)   && bus.mem_cmd_ready;
    assign wbeat_hs = (state_q == ST_WDATA) && bus.mem_wdata_ready;
    assign rbeat_hs = (state_q == ST_RDATA) && bus.mem_rdata_valid;

    beat_counter #(
        .WIDTH (IDX_W)
    ) u_beat (
        .clk     (clk),
        .rst_b   (rst_b),
        .clear_i (cmd_hs),
        .en_i    (wbeat_hs || rbeat_hs),
        .count_o (beat),
        .last_o  (beat_last)
    );

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= ST_IDLE;
            req_ready_q   <= 1'b1;
            cmd_valid_q   <= 1'b0;
            cmd_write_q   <= 1'b0;
            cmd_addr_q    <= '0;
            wdata_valid_q <= 1'b0;
            fill_valid_q  <= 1'b0;
            fill_idx_q    <= '0;
            fill_data_q   <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            fill_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        state_q     <= ST_CMD;
                        req_ready_q <= 1'b0;
                        cmd_valid_q <= 1'b1;
                        cmd_write_q <= bus.req_write;
                        cmd_addr_q  <= bus.req_addr & ~OFFSET_MASK;
                        err_q       <= 1'b0;
                    end
                end
                ST_CMD: begin
                    if (bus.mem_cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        if (cmd_write_q) begin
                            state_q       <= ST_WDATA;
                            wdata_valid_q <= 1'b1;
                        end else begin
                            state_q <= ST_RDATA;
                        end
                    end
                end
                ST_WDATA: begin
                    if (bus.mem_wdata_ready && beat_last) begin
                        state_q       <= ST_DONE;
                        wdata_valid_q <= 1'b0;
                        done_q        <= 1'b1;
                    end
                end
                ST_RDATA: begin
                    if (bus.mem_rdata_valid) begin
                        fill_valid_q <= 1'b1;
                        fill_idx_q   <= beat;
                        fill_data_q  <= bus.mem_rdata;
                        // rlast is only checked; the beat count alone ends the burst.
                        if (bus.mem_rlast != beat_last) begin
                            err_q <= 1'b1;
                        end
                        if (beat_last) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.req_ready       = req_ready_q;
    assign bus.mem_cmd_valid   = cmd_valid_q;
    assign bus.mem_cmd_write   = cmd_write_q;
    assign bus.mem_cmd_addr    = cmd_addr_q;
    assign bus.mem_wdata_valid = wdata_valid_q;
    assign bus.wb_word_idx     = wdata_valid_q ? beat : '0;
    assign bus.mem_wdata       = wdata_valid_q ? bus.wb_data : '0;
    assign bus.mem_wlast       = wdata_valid_q && beat_last;
    assign bus.fill_valid      = fill_valid_q;
    assign bus.fill_idx        = fill_idx_q;
    assign bus.fill_data       = fill_data_q;
    assign bus.done            = done_q;
    assign bus.err             = err_q;

endmodule

// File: doc/line_burst_engine.md
# line_burst_engine

Memory-side line transfer engine sitting directly downstream of the cache controller. Converts a single line refill or dirty-line writeback request into a 16-beat burst on the main-memory port, delivering refill words to the cache data array and fetching writeback words from it. Replaces the controller's single-word memory access with full-line transfers.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, word width
- `WORDS_PER_LINE`, 16, beats per line; must be a power of 2
- `OFFSET_W`, 6, line byte-offset bits
- `clk`  in  1  clock, all logic on rising edge
- `rst_b`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  controller requests a line transfer
- `req_ready`  out  1  engine idle, request accepted when `req_valid && req_ready`
- `req_write`  in  1  1 = writeback, 0 = refill
- `req_addr`  in  ADDR_W  line address; low OFFSET_W bits ignored
- `wb_word_idx`  out  4  word index presented to the cache data array during writeback
- `wb_data`  in  DATA_W  cache word for `wb_word_idx`, combinational, same cycle
- `fill_valid`  out  1  refill word valid, one cycle per word
- `fill_idx`  out  4  word index of `fill_data`
- `fill_data`  out  DATA_W  refill word
- `done`  out  1  one-cycle pulse, transaction complete
- `err`  out  1  sticky `mem_rlast` protocol error
- `mem_cmd_valid`  out  1  burst command valid
- `mem_cmd_ready`  in  1  memory accepts command
- `mem_cmd_write`  out  1  burst direction
- `mem_cmd_addr`  out  ADDR_W  line-aligned address (low OFFSET_W bits zero)
- `mem_wdata_valid`  out  1  write beat valid
- `mem_wdata_ready`  in  1  memory accepts write beat
- `mem_wdata`  out  DATA_W  write beat data
- `mem_wlast`  out  1  final write beat
- `mem_rdata_valid`  in  1  read beat valid; no backpressure, always accepted in RDATA
- `mem_rdata`  in  DATA_W  read beat data
- `mem_rlast`  in  1  final read beat marker

## Operation
- States: IDLE, CMD, WDATA, RDATA, DONE.
- IDLE: `req_ready`=1. On accept, latch `{req_addr[ADDR_W-1:OFFSET_W], 0}` and `req_write`, clear `err`, go CMD.
- CMD: `mem_cmd_valid`=1; addr and write held stable until `mem_cmd_ready`. On handshake, beat counter := 0, go WDATA (write) or RDATA (read).
- WDATA: `mem_wdata_valid`=1, `wb_word_idx`=beat, `mem_wdata`=`wb_data`, `mem_wlast`=(beat==15). Beat increments only on `mem_wdata_ready`; after beat 15 accepted, go DONE.
- RDATA: each `mem_rdata_valid` registers `fill_data`/`fill_idx`=beat and raises `fill_valid` next cycle; beat increments. After beat 15 received, go DONE. `err` set if `mem_rlast` != (beat==15) on any valid beat; beat count alone decides completion.
- DONE: `done`=1 for exactly one cycle, go IDLE. For refill, final `fill_valid` coincides with `done`.
- Beat counter 4-bit, wraps 15->0; never exceeds 16 beats per transaction.
- `mem_rdata_valid` outside RDATA is ignored.
- `wb_word_idx` = 0 outside WDATA.

## Timing
- Reset: state IDLE; `req_ready`=1; all other outputs 0; `err`=0.
- Reset mid-transaction: immediate abort to IDLE, no `done`, partial fills not retracted.
- Accept at cycle 0 -> `mem_cmd_valid` cycle 1.
- Writeback, zero stalls: beats cycles 2-17, `done` cycle 18.
- Refill, back-to-back rdata cycles 2-17: fills cycles 3-18, `done` cycle 18.
- `req_ready` low from cycle after accept until IDLE re-entered; new request accepted earliest cycle after `done`.

## Structure
- Shared package `cache_pkg`: WORDS_PER_LINE, OFFSET_W, index/tag widths, state encoding localparams.
- One sub-module natural: `beat_counter` (clear, enable, 4-bit count, `last` flag), reused by both data phases.

## Test plan
- Refill 0x0000_1040, cmd_ready immediate, rdata 0xA0..0xAF with rlast on beat 15 -> cmd_addr 0x0000_1040, write=0; fill_idx 0..15 data 0xA0..0xAF; done with last fill; err=0.
- Writeback 0x0000_0044, wb_data = 0xB0+idx, wdata_ready always 1 -> cmd_addr 0x0000_0040, beats 0xB0..0xBF, wlast only on 0xBF, done cycle 18.
- Writeback with wdata_ready low every other cycle -> mem_wdata stable while stalled, 16 beats exactly, no skipped index.
- Refill with rlast on beat 7 -> err=1 after beat 7, transfer continues to 16 beats, done; next request clears err.
- Refill with cmd_ready delayed 5 cycles, rdata gaps -> cmd held stable, fills only on valid beats.
- rst_b low during beat 6 of writeback -> immediate IDLE, req_ready=1, no done; following refill completes normally.
